// File: rtl/pic_cpu_bus_master_if.sv
// CPU-side command/response/vector handshake for the 8259A bus agent.
// master = requesting sequencer, slave = the bus agent itself.
interface pic_cpu_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic       cmd_a0;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       int_en;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic [7:0] vec_hi;
  logic [7:0] vec_opcode;

  modport master (
    output cmd_valid, cmd_rd, cmd_a0, cmd_wdata, int_en,
    input  cmd_ready, rsp_valid, rsp_data, vec_valid, vec_data, vec_hi, vec_opcode
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_a0, cmd_wdata, int_en,
    output cmd_ready, rsp_valid, rsp_data, vec_valid, vec_data, vec_hi, vec_opcode
  );
endinterface

// File: rtl/pic_cpu_bus_master.sv
// 8259A CPU-side bus agent: timed write/read cycles and INT acknowledge
// sequences, with every strobe, chip select and data-enable registered.
module pic_cpu_bus_master #(
  parameter bit          MODE_8086 = 1'b1,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 3,
  parameter int unsigned T_REC     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  pic_cpu_bus_master_if.slave        cpu,
  input  logic                       INT,
  output logic                       CS,
  output logic                       WR,
  output logic                       RD,
  output logic                       INTA,
  output logic                       A0,
  inout  wire  [7:0]                 D
);

  localparam logic [3:0] SETUP_L    = 4'(T_SETUP - 1);
  localparam logic [3:0] PULSE_L    = 4'(T_PULSE - 1);
  localparam logic [3:0] REC_L      = 4'(T_REC - 1);
  localparam logic [1:0] LAST_PULSE = MODE_8086 ? 2'd1 : 2'd2;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACK_LO, ACK_GAP, DONE, RECOVER
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] pulse, pulse_n;
  logic       op_rd, op_ack;
  logic [7:0] wdata;
  logic       d_oe;

  logic       cs_n, wr_n, rd_n, inta_n, doe_n;
  logic       ready, accept, ack_start, cap_rsp, cap_vec, rsp_pulse, vec_pulse;

  logic       rsp_valid_q, vec_valid_q;
  logic [7:0] rsp_data_q, vec_data_q, vec_hi_q, vec_opcode_q;

  assign D              = d_oe ? wdata : 'z;
  assign cpu.cmd_ready  = ready;
  assign cpu.rsp_valid  = rsp_valid_q;
  assign cpu.rsp_data   = rsp_data_q;
  assign cpu.vec_valid  = vec_valid_q;
  assign cpu.vec_data   = vec_data_q;
  assign cpu.vec_hi     = vec_hi_q;
  assign cpu.vec_opcode = vec_opcode_q;

  // Next-state and next-pin values; the pins themselves are registered below.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pulse_n   = pulse;
    cs_n      = CS;
    wr_n      = WR;
    rd_n      = RD;
    inta_n    = INTA;
    doe_n     = d_oe;
    ready     = 1'b0;
    accept    = 1'b0;
    ack_start = 1'b0;
    cap_rsp   = 1'b0;
    cap_vec   = 1'b0;
    rsp_pulse = 1'b0;
    vec_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu.int_en && INT) begin
          ack_start = 1'b1;
          state_n   = ACK_LO;
          inta_n    = 1'b0;
          cnt_n     = PULSE_L;
          pulse_n   = '0;
        end else begin
          ready = 1'b1;
          if (cpu.cmd_valid) begin
            accept  = 1'b1;
            state_n = SETUP;
            cs_n    = 1'b0;
            doe_n   = !cpu.cmd_rd;
            cnt_n   = SETUP_L;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = PULSE_L;
          if (op_rd) rd_n = 1'b0;
          else       wr_n = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          wr_n = 1'b1;
          rd_n = 1'b1;
          if (op_rd) begin
            cap_rsp   = 1'b1;
            rsp_pulse = 1'b1;
            state_n   = DONE;
          end else begin
            state_n = HOLD;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        state_n = RECOVER;
        cs_n    = 1'b1;
        doe_n   = 1'b0;
        cnt_n   = REC_L;
      end
      ACK_LO: begin
        if (cnt == '0) begin
          inta_n  = 1'b1;
          cap_vec = 1'b1;
          state_n = ACK_GAP;
          cnt_n   = REC_L;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK_GAP: begin
        if (cnt == '0) begin
          if (pulse == LAST_PULSE) begin
            state_n   = DONE;
            vec_pulse = 1'b1;
          end else begin
            pulse_n = pulse + 2'd1;
            state_n = ACK_LO;
            inta_n  = 1'b0;
            cnt_n   = PULSE_L;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        // The final INTA gap already provides recovery; reads still need CS released.
        if (op_ack) begin
          state_n = IDLE;
        end else begin
          state_n = RECOVER;
          cs_n    = 1'b1;
          cnt_n   = REC_L;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pulse        <= '0;
      op_rd        <= 1'b0;
      op_ack       <= 1'b0;
      wdata        <= '0;
      d_oe         <= 1'b0;
      CS           <= 1'b1;
      WR           <= 1'b1;
      RD           <= 1'b1;
      INTA         <= 1'b1;
      A0           <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      vec_valid_q  <= 1'b0;
      vec_data_q   <= '0;
      vec_hi_q     <= '0;
      vec_opcode_q <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pulse       <= pulse_n;
      CS          <= cs_n;
      WR          <= wr_n;
      RD          <= rd_n;
      INTA        <= inta_n;
      d_oe        <= doe_n;
      rsp_valid_q <= rsp_pulse;
      vec_valid_q <= vec_pulse;
      if (accept) begin
        op_rd  <= cpu.cmd_rd;
        op_ack <= 1'b0;
        A0     <= cpu.cmd_a0;
        wdata  <= cpu.cmd_wdata;
      end
      if (ack_start) begin
        op_rd  <= 1'b0;
        op_ack <= 1'b1;
      end
      if (cap_rsp) rsp_data_q <= D;
      if (cap_vec) begin
        if (MODE_8086) begin
          if (pulse == 2'd1) vec_data_q <= D;
        end else begin
          unique case (pulse)
            2'd0:    vec_opcode_q <= D;
            2'd1:    vec_data_q   <= D;
            default: vec_hi_q     <= D;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/pic_cpu_bus_master.md
Name: pic_cpu_bus_master

Overview:
- CPU-side bus agent for the 8259A PIC; drives the pins the PIC receives (CS, WR, RD, A0, INTA) and consumes its INT output.
- Turns single-beat command requests into timed write/read cycles (ICW/OCW programming, IRR/ISR/IMR reads).
- Answers INT with a complete interrupt-acknowledge sequence and returns the captured vector.
- Sits between the system CPU model or sequencer and the PIC in system benches and top-level integration.

Parameters:
- MODE_8086, 1, 1 = two INTA pulses with the vector on the 2nd; 0 = 8080 three-pulse sequence (opcode, low address byte, high address byte).
- T_SETUP, 2, cycles CS/A0/data are stable before the strobe falls (1..15).
- T_PULSE, 3, cycles WR/RD/INTA are held low (1..15).
- T_REC, 2, idle cycles after every transaction or between INTA pulses (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no acknowledge pending; a command is accepted when cmd_valid && cmd_ready.
- cmd_rd  in  1  1 = read cycle, 0 = write cycle.
- cmd_a0  in  1  value driven on A0 for the cycle.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_data  out  8  captured read data; held until the next read.
- int_en  in  1  enables automatic acknowledge of INT.
- INT  in  1  interrupt request from the PIC.
- vec_valid  out  1  one-cycle pulse; acknowledge sequence complete.
- vec_data  out  8  8086 mode: vector byte; 8080 mode: low address byte.
- vec_hi  out  8  8080 mode: high address byte; 8086 mode: 0.
- vec_opcode  out  8  8080 mode: first-pulse byte (expected 8'hCD); 8086 mode: 0.
- CS  out  1  chip select, active low.
- WR  out  1  write strobe, active low.
- RD  out  1  read strobe, active low.
- INTA  out  1  interrupt acknowledge, active low.
- A0  out  1  address line.
- D  inout  8  data bus; driven only during write cycles, otherwise high-Z.

Behaviour:
- Reset (async): CS = WR = RD = INTA = 1, A0 = 0, D released, all data/vector outputs = 0, rsp_valid = vec_valid = 0, FSM = IDLE. Reset mid-cycle deasserts strobes immediately; no response or vector is produced for the interrupted operation.
- States: IDLE, SETUP, STROBE, HOLD, ACK_LO, ACK_GAP, DONE, RECOVER.
- Every strobe and chip-select output is registered; no glitches.
- IDLE arbitration: if int_en && INT, enter ACK_LO; cmd_ready = 0 in that cycle. Otherwise cmd_ready = 1. Simultaneous INT and cmd_valid: the acknowledge wins, and the command waits.
- Write:
  - Acceptance edge latches A0/data and drives CS = 0 and D.
  - SETUP holds for T_SETUP cycles.
  - STROBE holds WR = 0 for T_PULSE cycles.
  - HOLD is 1 cycle with WR = 1 and CS/D still driven.
  - Then CS = 1, D is released, and the FSM enters RECOVER.
- Read:
  - Same CS/A0 timing as a write, D stays high-Z, and RD = 0 for T_PULSE cycles.
  - D is sampled on the final low cycle of RD.
  - rsp_valid pulses on the cycle after RD rises (DONE).
- Acknowledge:
  - CS stays 1 and D stays high-Z throughout.
  - Each pulse holds INTA = 0 for T_PULSE cycles, followed by ACK_GAP with INTA = 1 for T_REC cycles.
  - 8086 mode: 2 pulses; D is sampled at the end of pulse 2 into vec_data.
  - 8080 mode: 3 pulses; D is sampled into vec_opcode, then vec_data, then vec_hi.
  - The sequence always completes once started, even if INT or int_en drops (the PIC has already committed).
  - vec_valid pulses one cycle after the final gap.
- RECOVER: T_REC cycles with all strobes high, then IDLE. Back-to-back commands are therefore separated by at least T_REC cycles of CS = 1.
- Never more than one of WR/RD/INTA low in any cycle; CS is never low during INTA.
- Timing counters are 4-bit down-counters loaded with the parameter value minus 1.

Test Plan:
- Defaults, write a0 = 0, data 8'h13: CS low 6 cycles total, WR low exactly 3 cycles, D = 8'h13 from CS fall through 1 cycle after WR rise, then high-Z; cmd_ready returns 2 cycles after CS rises.
- Read a0 = 1 with the PIC model driving 8'hFB during RD: rsp_valid one pulse, rsp_data = 8'hFB; WR and INTA stay high throughout.
- MODE_8086 = 1, int_en = 1, INT raised, model returns 8'h48 on the 2nd INTA: exactly 2 INTA pulses of 3 cycles, 2 cycles apart; vec_valid pulse with vec_data = 8'h48; CS stays high.
- MODE_8086 = 0, bytes CD/40/12: 3 INTA pulses; vec_opcode = CD, vec_data = 40, vec_hi = 12.
- INT and cmd_valid rise in the same cycle: acknowledge completes first, then the write executes; INT dropped mid-acknowledge still yields both pulses.
- Reset asserted during the WR-low phase: WR and CS rise asynchronously, D goes high-Z, no rsp_valid or vec_valid, cmd_ready = 1 on the first clock after reset release.
